// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load-type encodings carried from MEM into WB.
package wb_pkg;

  localparam int LT_W = 3;

  typedef enum logic [LT_W-1:0] {
    LT_FULL = 3'b000,
    LT_B    = 3'b001,
    LT_BU   = 3'b010,
    LT_H    = 3'b011,
    LT_HU   = 3'b100
  } load_type_e;

endpackage

// File: rtl/wb_load_align.sv
// Selects the byte or half-word lane of a DRAM word and sign/zero-extends it to DATA_W.
module wb_load_align
  import wb_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int LANE_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [LT_W-1:0]   load_type,
  input  logic [LANE_W-1:0] addr_lo,
  output logic [DATA_W-1:0] result
);

  logic [LANE_W+2:0] byte_sh;
  logic [LANE_W+2:0] half_sh;
  logic [DATA_W-1:0] byte_shifted;
  logic [DATA_W-1:0] half_shifted;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  // A misaligned half-word drops the low address bit and reads the enclosing half lane.
  assign byte_sh = {addr_lo, 3'b000};
  assign half_sh = {addr_lo[LANE_W-1:1], 4'b0000};

  assign byte_shifted = data >> byte_sh;
  assign half_shifted = data >> half_sh;
  assign byte_v       = byte_shifted[7:0];
  assign half_v       = half_shifted[15:0];

  always_comb begin
    result = data;
    case (load_type)
      LT_B:    result = {{(DATA_W-8){byte_v[7]}}, byte_v};
      LT_BU:   result = {{(DATA_W-8){1'b0}}, byte_v};
      LT_H:    result = {{(DATA_W-16){half_v[15]}}, half_v};
      LT_HU:   result = {{(DATA_W-16){1'b0}}, half_v};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/writeback_stage_fwd.sv
// Final pipeline stage: registers MEM->WB, aligns load data, drives the regfile write port,
// keeps a short history of retired writes for forwarding, and counts retired instructions.
module writeback_stage_fwd
  import wb_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int REGADDR_W = 5,
  parameter  int FWD_DEPTH = 2,
  parameter  int CNT_W     = 32,
  localparam int LANE_W    = $clog2(DATA_W / 8)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 mem_valid,
  output logic                 wb_allowin,
  input  logic                 mem_wen,
  input  logic [REGADDR_W-1:0] mem_regsrc,
  input  logic                 mem_is_load,
  input  logic [LT_W-1:0]      mem_load_type,
  input  logic [LANE_W-1:0]    mem_addr_lo,
  input  logic [DATA_W-1:0]    mem_alu_result,
  input  logic [DATA_W-1:0]    dram_rdata,
  input  logic                 wb_stall,
  output logic                 wb_wen,
  output logic [REGADDR_W-1:0] wb_regsrc,
  output logic [DATA_W-1:0]    wb_regwdata,
  input  logic [REGADDR_W-1:0] fwd_rs_addr,
  output logic                 fwd_rs_hit,
  output logic [DATA_W-1:0]    fwd_rs_data,
  input  logic [REGADDR_W-1:0] fwd_rt_addr,
  output logic                 fwd_rt_hit,
  output logic [DATA_W-1:0]    fwd_rt_data,
  output logic [CNT_W-1:0]     retire_count
);

  logic                 wb_valid;
  logic                 wen_r;
  logic [REGADDR_W-1:0] regsrc_r;
  logic                 is_load_r;
  logic [LT_W-1:0]      load_type_r;
  logic [LANE_W-1:0]    addr_lo_r;
  logic [DATA_W-1:0]    alu_result_r;

  logic                 hold_valid;
  logic [DATA_W-1:0]    hold_data;

  logic                 hist_valid [FWD_DEPTH];
  logic [REGADDR_W-1:0] hist_addr  [FWD_DEPTH];
  logic [DATA_W-1:0]    hist_data  [FWD_DEPTH];

  logic                 transfer;
  logic                 retire;
  logic [DATA_W-1:0]    load_result;
  logic [DATA_W-1:0]    resolved_data;

  logic [REGADDR_W-1:0] q_addr [2];
  logic                 q_hit  [2];
  logic [DATA_W-1:0]    q_data [2];

  assign wb_allowin = !wb_valid || !wb_stall;
  assign transfer   = mem_valid && wb_allowin;
  assign retire     = wb_valid && !wb_stall;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wb_valid <= 1'b0;
    end else if (wb_allowin) begin
      wb_valid <= mem_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (transfer) begin
      wen_r        <= mem_wen;
      regsrc_r     <= mem_regsrc;
      is_load_r    <= mem_is_load;
      load_type_r  <= mem_load_type;
      addr_lo_r    <= mem_addr_lo;
      alu_result_r <= mem_alu_result;
    end
  end

  wb_load_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .data     (dram_rdata),
    .load_type(load_type_r),
    .addr_lo  (addr_lo_r),
    .result   (load_result)
  );

  assign resolved_data = is_load_r ? load_result : alu_result_r;

  // DRAM data is only valid in the first WB cycle, so a stalled result is frozen there.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_valid <= 1'b0;
    end else if (retire) begin
      hold_valid <= 1'b0;
    end else if (wb_valid && wb_stall && !hold_valid) begin
      hold_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wb_valid && wb_stall && !hold_valid) begin
      hold_data <= resolved_data;
    end
  end

  assign wb_regwdata = hold_valid ? hold_data : resolved_data;
  assign wb_regsrc   = regsrc_r;
  assign wb_wen      = retire && wen_r && (regsrc_r != '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < FWD_DEPTH; i++) begin
        hist_valid[i] <= 1'b0;
      end
    end else if (wb_wen) begin
      hist_valid[0] <= 1'b1;
      for (int i = FWD_DEPTH - 1; i > 0; i--) begin
        hist_valid[i] <= hist_valid[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wb_wen) begin
      hist_addr[0] <= regsrc_r;
      hist_data[0] <= wb_regwdata;
      for (int i = FWD_DEPTH - 1; i > 0; i--) begin
        hist_addr[i] <= hist_addr[i-1];
        hist_data[i] <= hist_data[i-1];
      end
    end
  end

  assign q_addr[0] = fwd_rs_addr;
  assign q_addr[1] = fwd_rt_addr;

  // Oldest entries are scanned first so younger matches overwrite them; the WB stage wins last.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      q_hit[p]  = 1'b0;
      q_data[p] = '0;
      for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
        if (hist_valid[i] && (hist_addr[i] == q_addr[p])) begin
          q_hit[p]  = 1'b1;
          q_data[p] = hist_data[i];
        end
      end
      if (wb_valid && wen_r && (regsrc_r == q_addr[p])) begin
        q_hit[p]  = 1'b1;
        q_data[p] = wb_regwdata;
      end
      if (q_addr[p] == '0) begin
        q_hit[p]  = 1'b0;
        q_data[p] = '0;
      end
    end
  end

  assign fwd_rs_hit  = q_hit[0];
  assign fwd_rs_data = q_data[0];
  assign fwd_rt_hit  = q_hit[1];
  assign fwd_rt_data = q_data[1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      retire_count <= '0;
    end else if (retire) begin
      retire_count <= retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
